// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states, idle NOP word, prefetch entry.
package ifu_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} ifu_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch FIFO: holds fetched {pc, instr} pairs; flush clears, push/pop may coincide.
module ifu_prefetch_fifo
   import ifu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head,
   output logic [CW-1:0]      count,
   output logic               empty
);

   fifo_entry_t   slot [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO still accepts a push when the head leaves on the same edge
   assign do_push = push && (!full || do_pop);
   assign head    = slot[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) slot[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loadable instruction memory, sequential prefetch, valid/ready output.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirect traps into HALT and raises misalign.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter  int          MEM_WORDS  = 64,
   parameter  int          FIFO_DEPTH = 2,
   parameter  logic [31:0] NOP_INSTR  = ifu_pkg::NOP_INSTR,
   localparam int          AW         = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          start,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   input  logic          instr_ready,
   output logic          instr_valid,
   output logic [31:0]   instruction,
   output logic [31:0]   instr_pc,
   output logic          busy
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,output logic          misalign
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;

   ifu_state_e  state;
   logic [31:0] fetch_pc;
   logic [31:0] rd_pc;
   logic [31:0] rd_data;
   logic        in_flight;
   logic [31:0] mem [MEM_WORDS];

   logic [31:0] redir_pc;
   logic        take_redirect;
   logic        xfer;
   logic        issue;
   logic [OW-1:0] occ;
   logic [OW-1:0] limit;

   fifo_entry_t   head;
   fifo_entry_t   push_entry;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic bad_align;
   assign bad_align = (redirect_pc[1:0] != 2'b00);
   assign redir_pc  = redirect_pc;
   assign misalign  = (state == HALT);
`else
   assign redir_pc  = redirect_pc & ~32'h3;
`endif

   assign take_redirect = redirect && (state != HALT);
   assign xfer          = instr_valid && instr_ready;

   // a head leaving this edge frees a slot, which keeps one word per cycle flowing
   assign occ   = OW'(fifo_count) + OW'(in_flight);
   assign limit = OW'(FIFO_DEPTH) + OW'(xfer);
   assign issue = (state == RUN) && !redirect && (occ < limit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= '0;
         rd_pc     <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
         if (issue) begin
            rd_pc    <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (take_redirect) begin
            in_flight <= 1'b0;
            fetch_pc  <= redir_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
            state     <= bad_align ? HALT : FLUSH;
`else
            state     <= FLUSH;
`endif
         end else begin
            case (state)
               IDLE:    if (start) state <= RUN;
               FLUSH:   state <= RUN;
               default: state <= state;
            endcase
         end
      end
   end

   // read-before-write: a same-index read during a load returns the old word
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      if (issue)   rd_data <= mem[fetch_pc[AW+1:2]];
   end

   assign push_entry = '{pc: rd_pc, instr: rd_data};

   ifu_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .flush     (take_redirect),
      .push      (in_flight),
      .push_data (push_entry),
      .pop       (xfer),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign instr_valid = !fifo_empty;
   assign instruction = instr_valid ? head.instr : NOP_INSTR;
   assign instr_pc    = instr_valid ? head.pc : 32'h0;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a PC-sequence reference model.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [5:0]  load_addr;
   logic [31:0] load_data;
   logic        start;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        busy;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .start       (start),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_ready (instr_ready),
      .instr_valid (instr_valid),
      .instruction (instruction),
      .instr_pc    (instr_pc),
      .busy        (busy)
`ifdef IFETCH_MISALIGN_TRAP_EN
     ,.misalign    (misalign)
`endif
   );

   int          cmp_n = 0;
   int          mis_n = 0;
   logic [31:0] mem_m [64];
   logic [31:0] exp_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      cmp_n++;
      assert (obs === exp_v) else begin
         mis_n++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // model: the next transfer must carry exp_pc and the memory word at (exp_pc/4) mod 64
   task automatic xfer_check(input string tag);
      chk({tag, "_pc"}, instr_pc, exp_pc);
      chk({tag, "_instr"}, instruction, mem_m[(exp_pc >> 2) % 64]);
      exp_pc = exp_pc + 32'd4;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20 && !instr_valid; i++) cyc();
      chk(tag, {31'b0, instr_valid}, 32'd1);
   endtask

   // ready held high: a word is expected every cycle
   task automatic stream(input string tag, input int n);
      instr_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
         if (instr_valid) xfer_check(tag);
         cyc();
      end
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      if (instr_valid && instr_ready) xfer_check("redir_hs");
      cyc();
      redirect = 1'b0;
   endtask

   logic        p_valid, p_ready, p_redir, r_redir;
   logic [31:0] p_pc, p_instr;
   int          n_xfer;

   initial begin
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      repeat (2) cyc();
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instruction, NOP);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 64; i++) begin
         mem_m[i]  = (i < 4) ? (32'h1234_5600 | 32'(i + 1)) : $urandom;
         load_en   = 1'b1;
         load_addr = 6'(i);
         load_data = mem_m[i];
         cyc();
      end
      load_en = 1'b0;
      chk("idle_valid", {31'b0, instr_valid}, 32'd0);

      // sequential fetch, first word two cycles after start
      exp_pc = 32'd0; instr_ready = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      chk("t1_busy", {31'b0, busy}, 32'd1);
      chk("t1_lat0", {31'b0, instr_valid}, 32'd0);
      cyc();
      chk("t1_lat1", {31'b0, instr_valid}, 32'd0);
      cyc();
      stream("t1", 8);

      // asynchronous reset while words are valid
      #3 reset = 1'b1;
      #1;
      chk("t5_valid", {31'b0, instr_valid}, 32'd0);
      chk("t5_busy", {31'b0, busy}, 32'd0);
      chk("t5_instr", instruction, NOP);
      @(posedge clk); #1;
      reset = 1'b0;

      // backpressure: head holds, then stream resumes without gaps
      exp_pc = 32'd0; instr_ready = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      wait_valid("t2_first");
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
         chk("t2_hold_pc", instr_pc, 32'd0);
         chk("t2_hold_instr", instruction, mem_m[0]);
         cyc();
      end
      stream("t2", 6);

      // redirect with a full FIFO
      instr_ready = 1'b0;
      repeat (3) cyc();
      chk("t3_full_valid", {31'b0, instr_valid}, 32'd1);
      redirect_to(32'h20);
      chk("t3_flush_valid", {31'b0, instr_valid}, 32'd0);
      exp_pc = 32'h20; instr_ready = 1'b1;
      wait_valid("t3_wait");
      stream("t3", 4);

      // index wrap past the top of memory
      redirect_to(32'hFC);
      exp_pc = 32'hFC;
      wait_valid("t4_wait");
      stream("t4", 4);

      // misaligned redirect
      redirect_to(32'h22);
`ifdef IFETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 8; i++) begin
         chk("t6_misalign", {31'b0, misalign}, 32'd1);
         chk("t6_valid", {31'b0, instr_valid}, 32'd0);
         start = (i == 2);
         cyc();
      end
      start = 1'b0;
      reset = 1'b1; cyc();
      chk("t6_rst_misalign", {31'b0, misalign}, 32'd0);
      reset = 1'b0;
      exp_pc = 32'd0;
      start = 1'b1; cyc(); start = 1'b0;
      wait_valid("t6_restart");
`else
      exp_pc = 32'h20;
      wait_valid("t6_wait");
      stream("t6", 3);
`endif

      // randomized ready and redirects against the PC-sequence model
      p_valid = 1'b0; p_ready = 1'b1; p_redir = 1'b1; p_pc = '0; p_instr = '0;
      n_xfer = 0;
      for (int i = 0; i < 400; i++) begin
         if (p_valid && !p_ready && !p_redir) begin
            chk("rnd_stable_valid", {31'b0, instr_valid}, 32'd1);
            chk("rnd_stable_pc", instr_pc, p_pc);
            chk("rnd_stable_instr", instruction, p_instr);
         end
         if (!instr_valid) chk("rnd_idle_nop", instruction, NOP);
         instr_ready = ($urandom_range(0, 3) != 0);
         r_redir     = ($urandom_range(0, 31) == 0);
         redirect    = r_redir;
         redirect_pc = $urandom & 32'h0000_01FC;
         if (instr_valid && instr_ready) begin
            xfer_check("rnd");
            n_xfer++;
         end
         if (r_redir) exp_pc = redirect_pc;
         p_valid = instr_valid; p_ready = instr_ready; p_redir = r_redir;
         p_pc = instr_pc; p_instr = instruction;
         cyc();
         redirect = 1'b0;
      end
      chk("rnd_progress", {31'b0, n_xfer > 100}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
      $finish;
   end

endmodule
